// File: rtl/sram_ring_ctrl_p.sv
// sram_ring_ctrl_p
//   Packs a T-symbol stream into a single-port SRAM and serves it to the PE
//   array as a circular buffer. It also runs an init sweep that clears every
//   score field while keeping headers and symbols intact.
//
//   Word layout (MSB first): header {valid, count}, then T_PER_WORD slots.
//   Slot k occupies bits [k*FIELD_W +: FIELD_W]. Its symbol sits in the slot
//   MSBs and the remaining bits hold score data.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   i_load_*       T beat stream (valid/ready, last, symbol count of last beat)
//   o_load_ready   beat accepted when valid & ready
//   i_init         start the score-clearing sweep (pulse)
//   o_busy         load, drain or init in progress
//   o_t_size       total stored symbols
//   i_rd_req       PE read request, accepted when o_rd_ready
//   o_rd_valid     read data strobe, READ_LAT cycles after acceptance
//   o_rd_data      read word, zero whenever o_rd_valid is low
//   i_wr_valid     PE write-back strobe (header bits of i_wr_data ignored)
//   o_overflow     one-cycle pulse: T did not fit in the SRAM
module sram_ring_ctrl_p #(
  parameter int WORD_W     = 256,
  parameter int ADDR_W     = 10,
  parameter int HDR_W      = 4,
  parameter int SYM_W      = 2,
  parameter int FIELD_W    = 36,
  parameter int T_PER_WORD = 7,
  parameter int READ_LAT   = 2,
  parameter int TS_W       = ADDR_W + 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_load_valid,
  input  logic [T_PER_WORD*SYM_W-1:0]  i_load_sym,
  input  logic                         i_load_last,
  input  logic [HDR_W-2:0]             i_load_nsym,
  output logic                         o_load_ready,
  input  logic                         i_init,
  output logic                         o_busy,
  output logic [TS_W-1:0]              o_t_size,
  input  logic                         i_rd_req,
  output logic                         o_rd_ready,
  output logic                         o_rd_valid,
  output logic [WORD_W-1:0]            o_rd_data,
  input  logic                         i_wr_valid,
  input  logic [WORD_W-1:0]            i_wr_data,
  output logic                         o_overflow
);

  localparam int BODY_W  = T_PER_WORD * FIELD_W;
  localparam int CNT_W   = HDR_W - 1;
  localparam int SCORE_W = FIELD_W - SYM_W;
  localparam int DEPTH   = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(T_PER_WORD);
  localparam logic [HDR_W-1:0]  HDR_MID  = {1'b1, {CNT_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_INIT_RD, S_INIT_WAIT, S_INIT_WR
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   load_addr_reg, load_addr_next;
  logic [ADDR_W-1:0]   init_addr_reg, init_addr_next;
  logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0]   last_addr_reg, last_addr_next;
  logic [HDR_W-1:0]    last_hdr_reg, last_hdr_next;
  logic                empty_reg, empty_next;
  logic [TS_W-1:0]     t_size_reg, t_size_next;
  logic                overflow_reg, overflow_next;
  logic                init_pulse_reg, init_pulse_next;

  // Single SRAM port
  logic [WORD_W-1:0]   mem [0:DEPTH-1];
  logic                mem_we, mem_re;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WORD_W-1:0]   mem_wdata;
  logic [WORD_W-1:0]   mem_q_reg;

  logic                rd_fire;
  logic                do_beat;
  logic [READ_LAT-1:0] vld_reg;
  logic [WORD_W-1:0]   rd_tail_data;

  // Beat bookkeeping: the first beat (seen in IDLE) restarts at address 0
  // with a zero symbol count.
  logic [ADDR_W-1:0]   beat_addr;
  logic [TS_W-1:0]     beat_base;
  logic [TS_W-1:0]     beat_inc;
  logic                beat_ovf;
  logic [HDR_W-1:0]    beat_hdr;
  logic [HDR_W-1:0]    wr_hdr;

  logic [BODY_W-1:0]   load_body;
  logic [BODY_W-1:0]   scrub_body;

  // Header bits of the write-back word are replaced by the controller.
  logic                unused_wr_hdr;
  assign unused_wr_hdr = ^i_wr_data[WORD_W-1 -: HDR_W];

  generate
    for (genvar gi = 0; gi < T_PER_WORD; gi++) begin : g_slot
      assign load_body[gi*FIELD_W +: FIELD_W] =
        {i_load_sym[gi*SYM_W +: SYM_W], {SCORE_W{1'b0}}};
      assign scrub_body[gi*FIELD_W +: FIELD_W] =
        {mem_q_reg[gi*FIELD_W+SCORE_W +: SYM_W], {SCORE_W{1'b0}}};
    end
  endgenerate

  assign beat_addr = (state_reg == S_IDLE) ? '0 : load_addr_reg;
  assign beat_base = (state_reg == S_IDLE) ? '0 : t_size_reg;
  // A non-last beat landing on the top address cannot be followed by more
  // storage, so it is closed off as a full final word.
  assign beat_ovf  = ~i_load_last & (beat_addr == TOP_ADDR);
  assign beat_hdr  = i_load_last ? {1'b1, i_load_nsym}
                   : (beat_ovf ? {1'b1, FULL_CNT} : HDR_MID);
  assign beat_inc  = i_load_last ? TS_W'(i_load_nsym) : TS_W'(T_PER_WORD);
  // The final word carries the symbol count; every other word is {1,0}.
  assign wr_hdr    = (wr_ptr_reg == last_addr_reg) ? last_hdr_reg : HDR_MID;

  assign o_load_ready = ((state_reg == S_IDLE) & ~i_init) |
                        (state_reg == S_LOAD) | (state_reg == S_DRAIN);
  assign o_rd_ready   = (state_reg == S_IDLE) & ~i_init & ~i_load_valid &
                        ~i_wr_valid & ~empty_reg;
  assign o_busy       = (state_reg != S_IDLE) | init_pulse_reg;
  assign o_t_size     = t_size_reg;
  assign o_overflow   = overflow_reg;

  always_comb begin
    state_next      = state_reg;
    load_addr_next  = load_addr_reg;
    init_addr_next  = init_addr_reg;
    rd_ptr_next     = rd_ptr_reg;
    wr_ptr_next     = wr_ptr_reg;
    last_addr_next  = last_addr_reg;
    last_hdr_next   = last_hdr_reg;
    empty_next      = empty_reg;
    t_size_next     = t_size_reg;
    overflow_next   = 1'b0;
    init_pulse_next = 1'b0;
    mem_we          = 1'b0;
    mem_re          = 1'b0;
    mem_addr        = rd_ptr_reg;
    mem_wdata       = '0;
    rd_fire         = 1'b0;
    do_beat         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (i_init) begin
          if (empty_reg) begin
            init_pulse_next = 1'b1;
          end else begin
            init_addr_next = '0;
            state_next     = S_INIT_RD;
          end
        end else if (i_load_valid) begin
          do_beat     = 1'b1;
          rd_ptr_next = '0;
          wr_ptr_next = '0;
          empty_next  = 1'b0;
        end else if (i_wr_valid) begin
          mem_we      = 1'b1;
          mem_addr    = wr_ptr_reg;
          mem_wdata   = {wr_hdr, i_wr_data[BODY_W-1:0]};
          wr_ptr_next = (wr_ptr_reg == last_addr_reg) ? '0 : wr_ptr_reg + 1'b1;
        end else if (i_rd_req && !empty_reg) begin
          mem_re      = 1'b1;
          mem_addr    = rd_ptr_reg;
          rd_fire     = 1'b1;
          rd_ptr_next = (rd_ptr_reg == last_addr_reg) ? '0 : rd_ptr_reg + 1'b1;
        end
      end
      S_LOAD: begin
        if (i_load_valid) do_beat = 1'b1;
      end
      S_DRAIN: begin
        if (i_load_valid && i_load_last) state_next = S_IDLE;
      end
      S_INIT_RD: begin
        mem_re     = 1'b1;
        mem_addr   = init_addr_reg;
        state_next = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        // mem_q_reg holds the word read in INIT_RD; no other read can
        // happen until the sweep ends.
        state_next = S_INIT_WR;
      end
      S_INIT_WR: begin
        mem_we    = 1'b1;
        mem_addr  = init_addr_reg;
        mem_wdata = {mem_q_reg[WORD_W-1 -: HDR_W], scrub_body};
        if (init_addr_reg == last_addr_reg) begin
          state_next  = S_IDLE;
          rd_ptr_next = '0;
          wr_ptr_next = '0;
        end else begin
          init_addr_next = init_addr_reg + 1'b1;
          state_next     = S_INIT_RD;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (do_beat) begin
      mem_we      = 1'b1;
      mem_addr    = beat_addr;
      mem_wdata   = {beat_hdr, load_body};
      t_size_next = beat_base + beat_inc;
      if (i_load_last) begin
        last_addr_next = beat_addr;
        last_hdr_next  = beat_hdr;
        state_next     = S_IDLE;
      end else if (beat_ovf) begin
        last_addr_next = beat_addr;
        last_hdr_next  = beat_hdr;
        overflow_next  = 1'b1;
        state_next     = S_DRAIN;
      end else begin
        load_addr_next = beat_addr + 1'b1;
        state_next     = S_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      load_addr_reg  <= '0;
      init_addr_reg  <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      last_addr_reg  <= '0;
      last_hdr_reg   <= '0;
      empty_reg      <= 1'b1;
      t_size_reg     <= '0;
      overflow_reg   <= 1'b0;
      init_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      load_addr_reg  <= load_addr_next;
      init_addr_reg  <= init_addr_next;
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      last_addr_reg  <= last_addr_next;
      last_hdr_reg   <= last_hdr_next;
      empty_reg      <= empty_next;
      t_size_reg     <= t_size_next;
      overflow_reg   <= overflow_next;
      init_pulse_reg <= init_pulse_next;
    end
  end

  // SRAM array: contents survive reset; accesses are blocked while in reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_addr] <= mem_wdata;
    if (mem_re && !rst) mem_q_reg <= mem[mem_addr];
  end

  // Read strobe pipeline; the SRAM output register is its first stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
    end else begin
      vld_reg[0] <= rd_fire;
      for (int i = 1; i < READ_LAT; i++) vld_reg[i] <= vld_reg[i-1];
    end
  end

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign rd_tail_data = mem_q_reg;
    end else begin : g_latn
      logic [WORD_W-1:0] stage_reg [0:READ_LAT-2];
      always_ff @(posedge clk) begin
        stage_reg[0] <= mem_q_reg;
        for (int i = 1; i < READ_LAT - 1; i++) stage_reg[i] <= stage_reg[i-1];
      end
      assign rd_tail_data = stage_reg[READ_LAT-2];
    end
  endgenerate

  assign o_rd_valid = vld_reg[READ_LAT-1];
  assign o_rd_data  = o_rd_valid ? rd_tail_data : '0;

endmodule

// File: tb/tb_sram_ring_ctrl_p.sv
// Self-checking bench for sram_ring_ctrl_p: directed steps and random
// operations, checked against a word-array model of the ring buffer.
module tb_sram_ring_ctrl_p;
  localparam int WORD_W   = 256;
  localparam int ADDR_W   = 3;
  localparam int HDR_W    = 4;
  localparam int SYM_W    = 2;
  localparam int FIELD_W  = 36;
  localparam int TPW      = 7;
  localparam int READ_LAT = 2;
  localparam int TS_W     = ADDR_W + 3;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int BODY_W   = TPW * FIELD_W;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [TPW*SYM_W-1:0] sym_t;
  typedef logic [HDR_W-2:0]     nsym_t;
  typedef logic [HDR_W-1:0]     hdr_t;
  typedef struct { int cyc; word_t data; } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_load_valid = 1'b0;
  sym_t        i_load_sym = '0;
  logic        i_load_last = 1'b0;
  nsym_t       i_load_nsym = '0;
  logic        o_load_ready;
  logic        i_init = 1'b0;
  logic        o_busy;
  logic [TS_W-1:0] o_t_size;
  logic        i_rd_req = 1'b0;
  logic        o_rd_ready;
  logic        o_rd_valid;
  word_t       o_rd_data;
  logic        i_wr_valid = 1'b0;
  word_t       i_wr_data = '0;
  logic        o_overflow;

  sram_ring_ctrl_p #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .HDR_W(HDR_W), .SYM_W(SYM_W),
    .FIELD_W(FIELD_W), .T_PER_WORD(TPW), .READ_LAT(READ_LAT), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst(rst),
    .i_load_valid(i_load_valid), .i_load_sym(i_load_sym),
    .i_load_last(i_load_last), .i_load_nsym(i_load_nsym),
    .o_load_ready(o_load_ready), .i_init(i_init), .o_busy(o_busy),
    .o_t_size(o_t_size), .i_rd_req(i_rd_req), .o_rd_ready(o_rd_ready),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_errors = 0;
  int      cyc = 0;
  int      ovf_seen = 0;
  rd_exp_t exp_q[$];

  // Reference model: stored words, symbol count, pointers, ring end.
  word_t   m_mem [DEPTH];
  int      m_t, m_rd, m_wr, m_last;
  bit      m_empty;
  word_t   body_mask, keep_mask;

  task automatic chk(input string tag, input word_t got, input word_t exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; checks the read strobe against the outstanding-read queue.
  task automatic tick();
    rd_exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (o_overflow) ovf_seen++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("rd_valid", word_t'(o_rd_valid), word_t'(1));
      chk("rd_data", o_rd_data, e.data);
      $display("rd   cyc=%0d data=%h", cyc, o_rd_data);
    end else begin
      chk("rd_idle_valid", word_t'(o_rd_valid), word_t'(0));
      chk("rd_idle_data", o_rd_data, word_t'(0));
    end
  endtask

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic word_t pack_load(input sym_t syms, input hdr_t hdr);
    word_t w, s, f;
    w = '0;
    s = word_t'(syms);
    for (int k = 0; k < TPW; k++) begin
      f = (s >> (k * SYM_W)) & word_t'((1 << SYM_W) - 1);
      w = w | (f << (k * FIELD_W + FIELD_W - SYM_W));
    end
    return w | (word_t'(hdr) << (WORD_W - HDR_W));
  endfunction

  function automatic int next_ptr(input int p);
    return (p == m_last) ? 0 : p + 1;
  endfunction

  task automatic load_seq(input int nbeats, input int nsym_last);
    int   addr, ovf0;
    bit   drain, last, want_ovf;
    sym_t syms;
    hdr_t hdr;
    ovf0 = ovf_seen; addr = 0; drain = 0; want_ovf = 0;
    m_t = 0; m_rd = 0; m_wr = 0; m_empty = 0;
    for (int b = 0; b < nbeats; b++) begin
      syms = sym_t'($urandom);
      last = (b == nbeats - 1);
      i_load_valid = 1'b1;
      i_load_sym   = syms;
      i_load_last  = last;
      i_load_nsym  = last ? nsym_t'(nsym_last) : nsym_t'($urandom_range(0, 7));
      #1;
      chk("load_ready", word_t'(o_load_ready), word_t'(1));
      if (!drain) begin
        if (last) begin
          hdr = {1'b1, nsym_t'(nsym_last)};
          m_t += nsym_last; m_last = addr;
        end else if (addr == DEPTH - 1) begin
          hdr = {1'b1, nsym_t'(TPW)};
          m_t += TPW; m_last = addr; drain = 1; want_ovf = 1;
        end else begin
          hdr = 4'h8;
          m_t += TPW;
        end
        m_mem[addr] = pack_load(syms, hdr);
        addr++;
      end
      tick();
      if (!last && !drain) chk("busy_loading", word_t'(o_busy), word_t'(1));
    end
    i_load_valid = 1'b0; i_load_last = 1'b0;
    chk("busy_after_last", word_t'(o_busy), word_t'(0));
    chk("t_size", word_t'(o_t_size), word_t'(m_t));
    tick();
    chk("overflow_pulses", word_t'(ovf_seen - ovf0), word_t'(want_ovf));
    $display("load beats=%0d nsym=%0d t_size=%0d last_addr=%0d", nbeats, nsym_last, m_t, m_last);
  endtask

  task automatic do_wr(input word_t d, input bit with_rd);
    hdr_t hdr;
    i_wr_valid = 1'b1; i_wr_data = d; i_rd_req = with_rd;
    #1;
    chk("rd_ready_during_wr", word_t'(o_rd_ready), word_t'(0));
    hdr = (m_wr == m_last) ? hdr_t'(m_mem[m_last] >> (WORD_W - HDR_W)) : 4'h8;
    m_mem[m_wr] = (word_t'(hdr) << (WORD_W - HDR_W)) | (d & body_mask);
    $display("wr   addr=%0d hdr=%h", m_wr, hdr);
    m_wr = next_ptr(m_wr);
    tick();
    i_wr_valid = 1'b0; i_rd_req = 1'b0;
  endtask

  task automatic do_rd(input int n);
    for (int i = 0; i < n; i++) begin
      i_rd_req = 1'b1;
      #1;
      chk("rd_ready", word_t'(o_rd_ready), word_t'(!m_empty));
      if (!m_empty) begin
        exp_q.push_back('{cyc: cyc + READ_LAT, data: m_mem[m_rd]});
        m_rd = next_ptr(m_rd);
      end
      tick();
    end
    i_rd_req = 1'b0;
  endtask

  task automatic flush();
    repeat (READ_LAT + 1) tick();
    chk("rd_drained", word_t'(exp_q.size()), word_t'(0));
  endtask

  task automatic do_init();
    int busy_cnt, want;
    i_init = 1'b1;
    #1;
    chk("load_ready_init", word_t'(o_load_ready), word_t'(0));
    tick();
    i_init = 1'b0;
    want = m_empty ? 1 : 3 * (m_last + 1);
    busy_cnt = 0;
    while (o_busy && busy_cnt < 200) begin
      busy_cnt++;
      tick();
    end
    chk("init_busy_cycles", word_t'(busy_cnt), word_t'(want));
    if (!m_empty) begin
      for (int a = 0; a <= m_last; a++) m_mem[a] = m_mem[a] & keep_mask;
      m_rd = 0; m_wr = 0;
    end
    $display("init busy_cycles=%0d", busy_cnt);
  endtask

  task automatic model_reset();
    m_t = 0; m_rd = 0; m_wr = 0; m_last = 0; m_empty = 1;
  endtask

  initial begin
    int op;
    body_mask = (word_t'(1) << BODY_W) - 1;
    keep_mask = ~body_mask;
    for (int k = 0; k < TPW; k++)
      keep_mask = keep_mask | (word_t'((1 << SYM_W) - 1) << (k * FIELD_W + FIELD_W - SYM_W));
    model_reset();

    // Reset state
    repeat (3) tick();
    chk("rst_t_size", word_t'(o_t_size), word_t'(0));
    chk("rst_busy", word_t'(o_busy), word_t'(0));
    chk("rst_overflow", word_t'(o_overflow), word_t'(0));
    rst = 1'b0;
    i_rd_req = 1'b1;
    #1;
    chk("rst_rd_ready_empty", word_t'(o_rd_ready), word_t'(0));
    chk("rst_load_ready", word_t'(o_load_ready), word_t'(1));
    tick();
    i_rd_req = 1'b0;

    // Init while empty: one-cycle busy pulse
    do_init();

    // Three beats, last carries 2 symbols
    load_seq(3, 2);
    do_rd(3);
    flush();

    // One full beat, four back-to-back reads wrap on word 0
    load_seq(1, 7);
    do_rd(4);
    flush();

    // Write-back ring and preserved final header
    load_seq(2, 7);
    do_rd(1);
    flush();
    do_wr(rand_word(), 1'b1);
    do_wr(rand_word(), 1'b0);
    do_wr(rand_word(), 1'b0);
    do_rd(2);
    flush();

    // Scores filled then scrubbed by init
    load_seq(2, 3);
    do_wr(rand_word(), 1'b0);
    do_wr(rand_word(), 1'b0);
    do_init();
    do_rd(2);
    flush();

    // Overflow: more non-last beats than addresses
    load_seq(DEPTH + 3, 5);
    do_rd(DEPTH);
    flush();

    // Reset in the middle of an init sweep
    load_seq(2, 4);
    i_init = 1'b1;
    tick();
    i_init = 1'b0;
    tick();
    chk("busy_init_wait", word_t'(o_busy), word_t'(1));
    rst = 1'b1;
    tick();
    chk("abort_busy", word_t'(o_busy), word_t'(0));
    chk("abort_t_size", word_t'(o_t_size), word_t'(0));
    rst = 1'b0;
    model_reset();

    // Random mix
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 1 || m_empty) begin
        load_seq($urandom_range(1, DEPTH), $urandom_range(1, TPW));
      end else if (op <= 4) begin
        do_wr(rand_word(), 1'($urandom_range(0, 1)));
      end else if (op <= 7) begin
        do_rd($urandom_range(1, 6));
      end else if (op == 8) begin
        do_init();
      end else begin
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    flush();
    do_rd(m_last + 1);
    flush();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
